mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//  Memory-stage load/store unit sitting directly downstream of the execute-stage ALU.
//  Takes the ALU result as effective address, and the funct3-encoded size/sign plus
//  store data. Runs one request/grant/response transaction on the data-memory port.
//  Returns byte-lane-extracted, sign/zero-extended load data and stalls upstream stages
//  until the access completes.
// PARAMETERS
//  DATA_WIDTH  32  datapath/address width (from defines); byte-enable width is DATA_WIDTH/8=4
// PORTS
//  clk            in   1   clock, rising edge
//  rst_n          in   1   asynchronous reset, active-low
//  mem_valid_i    in   1   EX/MEM register holds a valid instruction
//  mem_read_i     in   1   instruction is a load
//  mem_write_i    in   1   instruction is a store (wins if both read and write set)
//  funct3_i       in   3   000 B, 001 H, 010 W, 100 BU, 101 HU; others treated as W
//  alu_result_i   in   32  effective byte address
//  store_data_i   in   32  rs2 value for stores
//  stall_o        out  1   hold PC/IF/ID/EX/MEM registers
//  load_data_o    out  32  extended load result (registered)
//  load_valid_o   out  1   one-cycle pulse, load_data_o valid
//  misalign_o     out  1   one-cycle pulse, misaligned access dropped (macro only)
//  dmem_req_o     out  1   request, held until dmem_gnt_i
//  dmem_we_o      out  1   1=write
//  dmem_addr_o    out  32  word-aligned address ({addr[31:2],2'b00})
//  dmem_be_o      out  4   byte enables
//  dmem_wdata_o   out  32  lane-replicated store data
//  dmem_gnt_i     in   1   request accepted this cycle
//  dmem_rvalid_i  in   1   read data valid this cycle
//  dmem_rdata_i   in   32  read data word
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0. Async assert mid-transaction drops dmem_req_o
//   immediately. Any later rvalid/gnt is ignored.
//  FSM IDLE -> REQ -> (WAIT) -> DONE -> IDLE.
//   IDLE: accept when mem_valid_i & (mem_read_i|mem_write_i). Latch addr, funct3,
//    we, BE, wdata. Go to REQ. stall_o=1 combinationally in the accept cycle.
//   REQ: dmem_req_o=1. addr/we/be/wdata stable until gnt. On gnt: store->DONE, load->WAIT.
//   WAIT: on dmem_rvalid_i, register extended data -> DONE.
//   DONE: stall_o=0; load_valid_o=1 for loads. No accept in this cycle, because the same
//    instruction is still at the input. Next state IDLE.
//  stall_o = (state!=IDLE && state!=DONE) | accept.
//  Latency (zero-wait memory): store 2 stall cycles; load 3 stall cycles;
//   DONE is the release cycle.
//  gnt outside REQ and rvalid outside WAIT: ignored.
//  Lanes (a=addr[1:0]):
//   B: be=4'b0001<<a, wdata={4{d[7:0]}}.
//   H: be=a[1]?1100:0011, wdata={2{d[15:0]}}.
//   W: be=1111, wdata=d.
//  Load extract: B/BU byte at lane a; H/HU half at lane a[1]; W whole word.
//   B/H sign-extend; BU/HU zero-extend.
// CONFIGURATION
//  MEM_MISALIGN_TRAP_EN defined:
//   H with a[0]!=0, or W with a!=0: no dmem request issued; IDLE->DONE directly.
//   misalign_o=1 in DONE; load_valid_o=0; load_data_o unchanged.
//  Not defined: misalign_o tied 0. Low address bits beyond the lane select are ignored
//   and the access proceeds, e.g. W at 0x101 -> addr 0x100, be 1111.
// TESTING
//  1 SW addr 0x100, data 0xDEADBEEF, gnt immediate
//    -> addr 0x100, be 1111, we=1, stall 2 cycles, no load_valid.
//  2 LB addr 0x103, rdata 0x80FF1234 -> load_data 0xFFFFFF80; LBU same -> 0x00000080;
//    LHU 0x102 -> 0x000080FF.
//  3 SH addr 0x102, data 0x0000ABCD -> be 1100, wdata 0xABCDABCD, dmem_addr 0x100.
//  4 LW, gnt after 3 cycles, rvalid 2 cycles later -> req/addr stable until gnt,
//    stall continuous, single load_valid pulse.
//  5 rst_n low in WAIT -> req/stall/outputs 0 at once; later rvalid produces no load_valid.
//  6 LW addr 0x101: macro on -> no req, misalign_o pulse, stall 1 cycle;
//    macro off -> req addr 0x100, be 1111.

Source files
------------

// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit: one req/gnt/rvalid transaction per load or store, with lane steering and load extension.
// Optional MEM_MISALIGN_TRAP_EN drops misaligned H/W accesses and pulses misalign_o instead of touching memory.
module mem_access_unit #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_valid_i,
  input  logic              mem_read_i,
  input  logic              mem_write_i,
  input  logic [2:0]        funct3_i,
  input  logic [DATA_W-1:0] alu_result_i,
  input  logic [DATA_W-1:0] store_data_i,
  output logic              stall_o,
  output logic [DATA_W-1:0] load_data_o,
  output logic              load_valid_o,
  output logic              misalign_o,
  output logic              dmem_req_o,
  output logic              dmem_we_o,
  output logic [DATA_W-1:0] dmem_addr_o,
  output logic [DATA_W/8-1:0] dmem_be_o,
  output logic [DATA_W-1:0] dmem_wdata_o,
  input  logic              dmem_gnt_i,
  input  logic              dmem_rvalid_i,
  input  logic [DATA_W-1:0] dmem_rdata_i
);

  localparam int BE_W = DATA_W / 8;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t            state, state_nxt;
  logic              accept;
  logic              misalign_now;
  logic [DATA_W-1:0] addr_p1;
  logic [1:0]        lane_p1;
  logic [2:0]        f3_p1;
  logic [BE_W-1:0]   be_p1;
  logic [DATA_W-1:0] wdata_p1;
  logic              we_p1;
  logic              mis_p1;

  function automatic logic [BE_W-1:0] lane_be(input logic [2:0] f3, input logic [1:0] a);
    case (f3)
      3'b000, 3'b100: return BE_W'(4'b0001 << a);
      3'b001, 3'b101: return a[1] ? BE_W'(4'b1100) : BE_W'(4'b0011);
      default:        return '1;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] lane_wdata(input logic [2:0] f3, input logic [DATA_W-1:0] d);
    case (f3)
      3'b000, 3'b100: return {BE_W{d[7:0]}};
      3'b001, 3'b101: return {(BE_W/2){d[15:0]}};
      default:        return d;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] load_extract(input logic [2:0] f3, input logic [1:0] a,
                                                     input logic [DATA_W-1:0] w);
    logic        [7:0]        b;
    logic        [15:0]       h;
    logic signed [7:0]        b_s;
    logic signed [15:0]       h_s;
    logic signed [DATA_W-1:0] ext_s;
    b     = 8'(w >> {a, 3'b000});
    h     = a[1] ? w[31:16] : w[15:0];
    b_s   = b;
    h_s   = h;
    ext_s = '0;
    case (f3)
      3'b000:  begin ext_s = DATA_W'(b_s); return ext_s; end
      3'b001:  begin ext_s = DATA_W'(h_s); return ext_s; end
      3'b100:  return {{(DATA_W-8){1'b0}}, b};
      3'b101:  return {{(DATA_W-16){1'b0}}, h};
      default: return w;
    endcase
  endfunction

  // Accept is gated by rst_n so a held mem_valid_i cannot raise stall_o during reset.
  assign accept = rst_n && (state == IDLE) && mem_valid_i && (mem_read_i || mem_write_i);

`ifdef MEM_MISALIGN_TRAP_EN
  always_comb begin
    misalign_now = 1'b0;
    case (funct3_i)
      3'b000, 3'b100: misalign_now = 1'b0;
      3'b001, 3'b101: misalign_now = alu_result_i[0];
      default:        misalign_now = |alu_result_i[1:0];
    endcase
  end
`else
  assign misalign_now = 1'b0;
`endif

  // ---- stage p0 -> p1: capture request on accept ----
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_p1  <= {alu_result_i[DATA_W-1:2], 2'b00};
      lane_p1  <= alu_result_i[1:0];
      f3_p1    <= funct3_i;
      be_p1    <= lane_be(funct3_i, alu_result_i[1:0]);
      wdata_p1 <= lane_wdata(funct3_i, store_data_i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      we_p1  <= 1'b0;
      mis_p1 <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        we_p1  <= mem_write_i;
        mis_p1 <= misalign_now;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = misalign_now ? DONE : REQ;
      REQ:  if (dmem_gnt_i) state_nxt = we_p1 ? DONE : WAIT;
      WAIT: if (dmem_rvalid_i) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Bus fields are forced to zero outside REQ so idle and reset present an all-zero port.
  always_comb begin
    dmem_req_o   = 1'b0;
    dmem_we_o    = 1'b0;
    dmem_addr_o  = '0;
    dmem_be_o    = '0;
    dmem_wdata_o = '0;
    if (state == REQ) begin
      dmem_req_o   = 1'b1;
      dmem_we_o    = we_p1;
      dmem_addr_o  = addr_p1;
      dmem_be_o    = be_p1;
      dmem_wdata_o = wdata_p1;
    end
  end

  assign stall_o      = (state == REQ) || (state == WAIT) || accept;
  assign load_valid_o = (state == DONE) && !we_p1 && !mis_p1;
  assign misalign_o   = (state == DONE) && mis_p1;

  // ---- stage p1 -> p2: extended load result ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_data_o <= '0;
    end else if ((state == WAIT) && dmem_rvalid_i) begin
      load_data_o <= load_extract(f3_p1, lane_p1, dmem_rdata_i);
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: stimulus pushes expected bus requests and load results, a monitor pops and compares.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_valid_i = 1'b0, mem_read_i = 1'b0, mem_write_i = 1'b0;
  logic [2:0]  funct3_i = '0;
  logic [31:0] alu_result_i = '0, store_data_i = '0;
  logic        stall_o, load_valid_o, misalign_o;
  logic [31:0] load_data_o;
  logic        dmem_req_o, dmem_we_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o;
  logic [3:0]  dmem_be_o;
  logic        dmem_gnt_i = 1'b0, dmem_rvalid_i = 1'b0;
  logic [31:0] dmem_rdata_i = '0;

  mem_access_unit #(.DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_valid_i(mem_valid_i), .mem_read_i(mem_read_i), .mem_write_i(mem_write_i),
    .funct3_i(funct3_i), .alu_result_i(alu_result_i), .store_data_i(store_data_i),
    .stall_o(stall_o), .load_data_o(load_data_o), .load_valid_o(load_valid_o),
    .misalign_o(misalign_o),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
    .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o),
    .dmem_gnt_i(dmem_gnt_i), .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } req_t;

  req_t        req_q[$];
  logic [31:0] ld_q[$];
  int          mis_pending = 0;
  int          checks = 0;
  int          failures = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%h required=0x%h", name, act, exp);
    end
  endtask

  // Monitor: samples 2 time units after the falling edge, after stimulus has set gnt/rvalid.
  always @(negedge clk) begin
    #2;
    if (rst_n) begin
      if (dmem_req_o) begin
        if (req_q.size() == 0) begin
          check32("unexpected_req_qsize", 32'(req_q.size()), 32'd1);
        end else begin
          check32("req_addr",  dmem_addr_o,       req_q[0].addr);
          check32("req_we",    32'(dmem_we_o),    32'(req_q[0].we));
          check32("req_be",    32'(dmem_be_o),    32'(req_q[0].be));
          check32("req_wdata", dmem_wdata_o,      req_q[0].wdata);
          if (dmem_gnt_i) void'(req_q.pop_front());
        end
      end
      if (load_valid_o) begin
        if (ld_q.size() == 0) check32("unexpected_load_valid_qsize", 32'(ld_q.size()), 32'd1);
        else                  check32("load_data", load_data_o, ld_q.pop_front());
      end
      if (misalign_o) begin
        check32("unexpected_misalign", 32'(mis_pending > 0), 32'd1);
        if (mis_pending > 0) mis_pending--;
      end
    end
  end

  // Issue one instruction at the MEM input and play the memory side; starts and ends 1 unit after a rising edge.
  task automatic do_access(input string name, input logic rd, input logic wr, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] d, input int gdly, input int rdly,
                           input logic [31:0] rdata, input int exp_stall);
    int stalls = 0;
    int reqc   = 0;
    int wcnt   = 0;
    bit gseen  = 1'b0;
    bit done   = 1'b0;
    mem_valid_i = 1'b1; mem_read_i = rd; mem_write_i = wr;
    funct3_i = f3; alu_result_i = a; store_data_i = d;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      @(negedge clk);
      dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = '0;
      if (!stall_o) begin
        done = 1'b1;
      end else begin
        stalls++;
        if (dmem_req_o) begin
          if (reqc == gdly) begin dmem_gnt_i = 1'b1; gseen = 1'b1; end
          reqc++;
        end else if (gseen) begin
          if (wcnt == rdly) begin dmem_rvalid_i = 1'b1; dmem_rdata_i = rdata; end
          wcnt++;
        end
      end
    end
    if (!done) $display("FAIL %s_timeout actual=stalled required=release", name);
    check32({name, "_stall"}, 32'(stalls), 32'(exp_stall));
    @(posedge clk); #1;
    mem_valid_i = 1'b0; mem_read_i = 1'b0; mem_write_i = 1'b0;
  endtask

  task automatic store(input string name, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                       input logic both, input logic [3:0] be, input logic [31:0] wd);
    req_q.push_back('{addr: {a[31:2], 2'b00}, we: 1'b1, be: be, wdata: wd});
    do_access(name, both, 1'b1, f3, a, d, 0, 0, 32'h0, 2);
  endtask

  task automatic load(input string name, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rdata,
                      input logic [3:0] be, input logic [31:0] exp_data, input int gdly, input int rdly);
    req_q.push_back('{addr: {a[31:2], 2'b00}, we: 1'b0, be: be, wdata: 32'h0});
    ld_q.push_back(exp_data);
    do_access(name, 1'b1, 1'b0, f3, a, 32'h0, gdly, rdly, rdata, 3 + gdly + rdly);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check32("rst_stall",      32'(stall_o),      32'h0);
    check32("rst_req",        32'(dmem_req_o),   32'h0);
    check32("rst_we",         32'(dmem_we_o),    32'h0);
    check32("rst_addr",       dmem_addr_o,       32'h0);
    check32("rst_be",         32'(dmem_be_o),    32'h0);
    check32("rst_wdata",      dmem_wdata_o,      32'h0);
    check32("rst_load_valid", 32'(load_valid_o), 32'h0);
    check32("rst_misalign",   32'(misalign_o),   32'h0);
    check32("rst_load_data",  load_data_o,       32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Stores: SW, SH upper half, SB with read also set (store wins).
    store("sw_100",  3'b010, 32'h100, 32'hDEADBEEF, 1'b0, 4'b1111, 32'hDEADBEEF);
    store("sh_102",  3'b001, 32'h102, 32'h0000ABCD, 1'b0, 4'b1100, 32'hABCDABCD);
    store("sb_101",  3'b000, 32'h101, 32'h000000A5, 1'b1, 4'b0010, 32'hA5A5A5A5);

    // Loads with zero-wait memory from word 0x80FF1234.
    load("lb_103",  3'b000, 32'h103, 32'h80FF1234, 4'b1000, 32'hFFFFFF80, 0, 0);
    load("lbu_103", 3'b100, 32'h103, 32'h80FF1234, 4'b1000, 32'h00000080, 0, 0);
    load("lhu_102", 3'b101, 32'h102, 32'h80FF1234, 4'b1100, 32'h000080FF, 0, 0);
    load("lh_102",  3'b001, 32'h102, 32'h80FF1234, 4'b1100, 32'hFFFF80FF, 0, 0);
    load("lh_100",  3'b001, 32'h100, 32'h80FF1234, 4'b0011, 32'h00001234, 0, 0);
    load("lb_101",  3'b000, 32'h101, 32'h80FF1234, 4'b0010, 32'h00000012, 0, 0);
    load("lf7_108", 3'b111, 32'h108, 32'h01020304, 4'b1111, 32'h01020304, 0, 0);
    load("lw_104",  3'b010, 32'h104, 32'h80FF1234, 4'b1111, 32'h80FF1234, 0, 0);

`ifdef MEM_MISALIGN_TRAP_EN
    mis_pending = 1;
    do_access("lw_101_trap", 1'b1, 1'b0, 3'b010, 32'h101, 32'h0, 0, 0, 32'h11223344, 1);
    check32("trap_load_data_kept", load_data_o, 32'h80FF1234);
    check32("trap_mis_consumed", 32'(mis_pending), 32'h0);
`else
    load("lw_101", 3'b010, 32'h101, 32'h11223344, 4'b1111, 32'h11223344, 0, 0);
`endif

    // Slow memory: grant on the 4th request cycle, rvalid on the 3rd wait cycle.
    load("lw_slow", 3'b010, 32'h200, 32'hCAFEF00D, 4'b1111, 32'hCAFEF00D, 3, 2);

    // Reset while the request is outstanding drops dmem_req_o at once.
    req_q.push_back('{addr: 32'h300, we: 1'b0, be: 4'b1111, wdata: 32'h0});
    mem_valid_i = 1'b1; mem_read_i = 1'b1; funct3_i = 3'b010; alu_result_i = 32'h300; store_data_i = '0;
    @(negedge clk);
    @(negedge clk);
    #3;
    check32("req_before_reset", 32'(dmem_req_o), 32'h1);
    rst_n = 1'b0; mem_valid_i = 1'b0; mem_read_i = 1'b0;
    #1;
    check32("req_reset_in_req",   32'(dmem_req_o), 32'h0);
    check32("stall_reset_in_req", 32'(stall_o),    32'h0);
    req_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk); dmem_gnt_i = 1'b1;
    @(negedge clk); dmem_gnt_i = 1'b0;
    #3;
    check32("stray_gnt_req",   32'(dmem_req_o), 32'h0);
    check32("stray_gnt_stall", 32'(stall_o),    32'h0);
    @(posedge clk); #1;

    // Reset while waiting for read data; the late rvalid must be ignored.
    req_q.push_back('{addr: 32'h400, we: 1'b0, be: 4'b1111, wdata: 32'h0});
    mem_valid_i = 1'b1; mem_read_i = 1'b1; funct3_i = 3'b010; alu_result_i = 32'h400;
    @(negedge clk);
    @(negedge clk); dmem_gnt_i = 1'b1;
    @(negedge clk); dmem_gnt_i = 1'b0;
    #3;
    check32("stall_in_wait", 32'(stall_o), 32'h1);
    rst_n = 1'b0; mem_valid_i = 1'b0; mem_read_i = 1'b0;
    #1;
    check32("stall_reset_in_wait",      32'(stall_o),      32'h0);
    check32("req_reset_in_wait",        32'(dmem_req_o),   32'h0);
    check32("load_valid_reset_in_wait", 32'(load_valid_o), 32'h0);
    check32("load_data_reset_in_wait",  load_data_o,       32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk); dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h5555AAAA;
    @(negedge clk); dmem_rvalid_i = 1'b0; dmem_rdata_i = '0;
    #3;
    check32("late_rvalid_load_data", load_data_o,       32'h0);
    check32("late_rvalid_stall",     32'(stall_o),      32'h0);
    @(negedge clk);
    #3;
    check32("late_rvalid_load_valid", 32'(load_valid_o), 32'h0);

    repeat (3) @(posedge clk);
    #1;
    check32("req_q_drained",  32'(req_q.size()), 32'h0);
    check32("ld_q_drained",   32'(ld_q.size()),  32'h0);
    check32("mis_drained",    32'(mis_pending),  32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
